// File: rtl/atm_pkg.sv
// Shared constants and encodings for the ATM controller: account table,
// "no match" index and top-level ATM state encodings.
package atm_pkg;

    localparam int NUM_ACC_DEF   = 10;
    localparam int MAX_FAILS_DEF = 3;

    localparam logic [3:0] NO_INDEX = 4'hF;

    // Sized to the full 4-bit index space so any index lookup stays in range.
    localparam logic [3:0] ACC_NUM [16] = '{
        4'd0,  4'd1,  4'd2,  4'd3,  4'd4,  4'd5,  4'd6,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    localparam logic [15:0] ACC_PIN [16] = '{
        16'd1000, 16'd1001, 16'd1002, 16'd1003, 16'd1004, 16'd1005, 16'd1006, 16'd1007,
        16'd1008, 16'd1009, 16'd1010, 16'd1011, 16'd1012, 16'd1013, 16'd1014, 16'd1015
    };

    typedef enum logic [2:0] {
        WAITING  = 3'd0,
        MENU     = 3'd1,
        BALANCE  = 3'd2,
        WITHDRAW = 3'd3,
        DEPOSIT  = 3'd4,
        EXIT     = 3'd5
    } atm_state_e;

endpackage

// File: rtl/atm_authenticator_if.sv
// Request/response bundle between the ATM state machine and the authenticator.
interface atm_authenticator_if;

    logic        req;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [3:0]  acc_index;
    logic        acc_found_stat;
    logic        acc_auth_stat;
    logic        acc_locked;

    modport master (
        output req, acc_num, pin,
        input  acc_index, acc_found_stat, acc_auth_stat, acc_locked
    );

    modport slave (
        input  req, acc_num, pin,
        output acc_index, acc_found_stat, acc_auth_stat, acc_locked
    );

endinterface

// File: rtl/atm_acc_lookup.sv
// Combinational priority match of a presented account number against the
// account table; the lowest matching entry wins.
module atm_acc_lookup
    import atm_pkg::*;
#(
    parameter int NUM_ACC = NUM_ACC_DEF
) (
    input  logic [3:0] acc_num,
    output logic       hit_s,
    output logic [3:0] idx_s
);

    // Scan entries in ascending order, latching only the first match.
    always_comb begin
        hit_s = 1'b0;
        idx_s = NO_INDEX;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (!hit_s && (ACC_NUM[i] == acc_num)) begin
                hit_s = 1'b1;
                idx_s = 4'(i);
            end else begin
                hit_s = hit_s;
                idx_s = idx_s;
            end
        end
    end

endmodule

// File: rtl/atm_authenticator.sv
// Card/PIN authenticator: table lookup, per-account wrong-PIN counting with
// lockout, and registered status outputs with one-cycle latency.
module atm_authenticator
    import atm_pkg::*;
#(
    parameter int NUM_ACC   = NUM_ACC_DEF,
    parameter int MAX_FAILS = MAX_FAILS_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    atm_authenticator_if.slave bus
);

    localparam int              CW      = $clog2(MAX_FAILS + 1);
    localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_FAILS);

    logic          hit_s;
    logic [3:0]    idx_s;
    logic          cur_lock_s;
    logic [CW-1:0] cur_cnt_s;
    logic [CW-1:0] cnt_inc_s;
    logic          new_lock_s;
    logic          pin_ok_s;

    logic [CW-1:0] fail_cnt_r [NUM_ACC];
    logic          lock_r     [NUM_ACC];
    logic [3:0]    acc_index_r;
    logic          found_r;
    logic          auth_r;
    logic          locked_r;

    atm_acc_lookup #(.NUM_ACC(NUM_ACC)) u_lookup (
        .acc_num (bus.acc_num),
        .hit_s   (hit_s),
        .idx_s   (idx_s)
    );

    // Select the matched account's counter/lock and derive the failure outcome.
    always_comb begin
        cur_lock_s = 1'b0;
        cur_cnt_s  = '0;
        for (int i = 0; i < NUM_ACC; i++) begin
            if (hit_s && (idx_s == 4'(i))) begin
                cur_lock_s = lock_r[i];
                cur_cnt_s  = fail_cnt_r[i];
            end else begin
                cur_lock_s = cur_lock_s;
                cur_cnt_s  = cur_cnt_s;
            end
        end
        pin_ok_s   = hit_s && (bus.pin == ACC_PIN[idx_s]);
        cnt_inc_s  = (cur_cnt_s >= MAX_CNT) ? MAX_CNT : (cur_cnt_s + CW'(1));
        new_lock_s = (cnt_inc_s == MAX_CNT);
    end

    // Account state and response registers, updated only on a request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACC; i++) begin
                fail_cnt_r[i] <= '0;
                lock_r[i]     <= 1'b0;
            end
            acc_index_r <= NO_INDEX;
            found_r     <= 1'b0;
            auth_r      <= 1'b0;
            locked_r    <= 1'b0;
        end else if (bus.req) begin
            // Locked accounts ignore the PIN; a correct PIN never clears the lock.
            for (int i = 0; i < NUM_ACC; i++) begin
                if (hit_s && (idx_s == 4'(i)) && !cur_lock_s) begin
                    if (pin_ok_s) begin
                        fail_cnt_r[i] <= '0;
                        lock_r[i]     <= lock_r[i];
                    end else begin
                        fail_cnt_r[i] <= cnt_inc_s;
                        lock_r[i]     <= new_lock_s;
                    end
                end else begin
                    fail_cnt_r[i] <= fail_cnt_r[i];
                    lock_r[i]     <= lock_r[i];
                end
            end
            acc_index_r <= hit_s ? idx_s : NO_INDEX;
            found_r     <= hit_s;
            auth_r      <= hit_s && !cur_lock_s && pin_ok_s;
            locked_r    <= hit_s && (cur_lock_s || (!pin_ok_s && new_lock_s));
        end else begin
            acc_index_r <= acc_index_r;
            found_r     <= found_r;
            auth_r      <= auth_r;
            locked_r    <= locked_r;
        end
    end

    assign bus.acc_index      = acc_index_r;
    assign bus.acc_found_stat = found_r;
    assign bus.acc_auth_stat  = auth_r;
    assign bus.acc_locked     = locked_r;

endmodule

// File: tb/tb_atm_authenticator.sv
// Directed-vector bench for atm_authenticator with immediate-assertion checks.
module tb_atm_authenticator;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    atm_authenticator_if bus ();

    atm_authenticator #(.NUM_ACC(10), .MAX_FAILS(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] idx, input logic fnd,
                           input logic ath, input logic lck);
        chk({tag, ".index"},  16'(bus.acc_index),      16'(idx));
        chk({tag, ".found"},  16'(bus.acc_found_stat), 16'(fnd));
        chk({tag, ".auth"},   16'(bus.acc_auth_stat),  16'(ath));
        chk({tag, ".locked"}, 16'(bus.acc_locked),     16'(lck));
    endtask

    // Drive a request at the falling edge, sample one edge later.
    task automatic step(input logic [3:0] a, input logic [15:0] p);
        @(negedge clk);
        bus.req     = 1'b1;
        bus.acc_num = a;
        bus.pin     = p;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req     = 1'b0;
        bus.acc_num = 4'd0;
        bus.pin     = 16'd0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        bus.req     = 1'b0;
        bus.acc_num = 4'd0;
        bus.pin     = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step(4'd3, 16'd1003);   chk_out("acc3_ok", 4'd3, 1'b1, 1'b1, 1'b0);
        step(4'd12, 16'd1012);  chk_out("acc12_nf", 4'hF, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            idle();             chk_out("hold_nf", 4'hF, 1'b0, 1'b0, 1'b0);
        end
        step(4'd15, 16'd1015);  chk_out("acc15_nf", 4'hF, 1'b0, 1'b0, 1'b0);

        // Two failures then success clears the counter for account 5.
        step(4'd5, 16'd0);      chk_out("acc5_bad1", 4'd5, 1'b1, 1'b0, 1'b0);
        step(4'd5, 16'd0);      chk_out("acc5_bad2", 4'd5, 1'b1, 1'b0, 1'b0);
        step(4'd5, 16'd1005);   chk_out("acc5_ok", 4'd5, 1'b1, 1'b1, 1'b0);
        step(4'd5, 16'd0);      chk_out("acc5_bad3", 4'd5, 1'b1, 1'b0, 1'b0);
        step(4'd5, 16'd0);      chk_out("acc5_bad4", 4'd5, 1'b1, 1'b0, 1'b0);

        // Lock account 7; other accounts unaffected.
        step(4'd7, 16'd1);      chk_out("acc7_bad1", 4'd7, 1'b1, 1'b0, 1'b0);
        step(4'd7, 16'd1);      chk_out("acc7_bad2", 4'd7, 1'b1, 1'b0, 1'b0);
        step(4'd7, 16'd1);      chk_out("acc7_lock", 4'd7, 1'b1, 1'b0, 1'b1);
        step(4'd7, 16'd1007);   chk_out("acc7_locked_ok", 4'd7, 1'b1, 1'b0, 1'b1);
        step(4'd6, 16'd1006);   chk_out("acc6_ok", 4'd6, 1'b1, 1'b1, 1'b0);
        idle();                 chk_out("hold_acc6a", 4'd6, 1'b1, 1'b1, 1'b0);
        idle();                 chk_out("hold_acc6b", 4'd6, 1'b1, 1'b1, 1'b0);

        // Lock account 2, then reset asynchronously mid-cycle.
        step(4'd2, 16'd2);      chk_out("acc2_bad1", 4'd2, 1'b1, 1'b0, 1'b0);
        step(4'd2, 16'd2);      chk_out("acc2_bad2", 4'd2, 1'b1, 1'b0, 1'b0);
        step(4'd2, 16'd2);      chk_out("acc2_lock", 4'd2, 1'b1, 1'b0, 1'b1);
        bus.req = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 4'hF, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'd2, 16'd1002);   chk_out("acc2_after_rst", 4'd2, 1'b1, 1'b1, 1'b0);
        step(4'd7, 16'd1007);   chk_out("acc7_after_rst", 4'd7, 1'b1, 1'b1, 1'b0);

        // Back-to-back requests: each result lands exactly one cycle later.
        for (int i = 0; i < 3; i++) begin
            step(4'd0, 16'd1000); chk_out("b2b_acc0", 4'd0, 1'b1, 1'b1, 1'b0);
            step(4'd9, 16'd1009); chk_out("b2b_acc9", 4'd9, 1'b1, 1'b1, 1'b0);
        end
        step(4'd10, 16'd1010);  chk_out("acc10_nf", 4'hF, 1'b0, 1'b0, 1'b0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
